dmem_responder: RTL and testbench

// - Data-memory responder: the target end of the core's load/store memory-control interface.
// - Accepts one load/store request per handshake and applies byte/half/word write masks.
// - Returns sign/zero-extended load data one cycle later, holding it under back-pressure.
// - Sits between the MEM pipeline stage (initiator) and a DEPTH x 32-bit data array held inside this block.

---
 rtl/dmem_responder.sv | 96 +++++++++
 tb/tb_dmem_responder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: load/store target with byte masks, extended load data and one-deep held response
module dmem_responder #(
  parameter int DEPTH = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_mem_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_w_data,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_r_data,
  output logic [4:0]  resp_rd,
  output logic        resp_is_store,
  output logic        resp_err
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  typedef enum logic {IDLE, RESP} state_e;
  state_e state_q, state_d;
  logic [31:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0] lane;
  logic accept, take, is_nop, is_load, is_store, misaligned, err, wr_en;
  logic [3:0] wmask;
  logic [31:0] wdata, word, load_data;
  logic [7:0] rbyte;
  logic [15:0] rhalf;
  logic [31:0] resp_r_data_q, resp_r_data_d;
  logic [4:0] resp_rd_q, resp_rd_d;
  logic resp_is_store_q, resp_is_store_d, resp_err_q, resp_err_d;
  logic unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];
  assign accept = req_valid && req_ready;
  assign take = accept && !is_nop;
  always_comb begin
    idx = req_addr[ADDR_WIDTH+1:2];
    lane = req_addr[1:0];
    is_nop = req_mem_op == 4'b1111;
    is_load = req_mem_op inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101};
    is_store = req_mem_op inside {4'b1000, 4'b1001, 4'b1010};
    misaligned = (req_mem_op[1:0] == 2'b01 && lane[0]) || (req_mem_op[1:0] == 2'b10 && lane != 2'b00);
    err = !(is_load || is_store) || misaligned;
    wr_en = accept && is_store && !misaligned;
    wmask = req_mem_op[1:0] == 2'b00 ? 4'(4'b0001 << lane) :
            req_mem_op[1:0] == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata = req_mem_op[1:0] == 2'b00 ? {4{req_w_data[7:0]}} :
            req_mem_op[1:0] == 2'b01 ? {2{req_w_data[15:0]}} : req_w_data;
    word = mem_q[idx];
    rbyte = word[8*lane +: 8];
    rhalf = lane[1] ? word[31:16] : word[15:0];
    load_data = req_mem_op[1:0] == 2'b00 ? {{24{rbyte[7] & !req_mem_op[2]}}, rbyte} :
                req_mem_op[1:0] == 2'b01 ? {{16{rhalf[15] & !req_mem_op[2]}}, rhalf} : word;
  end
  always_ff @(posedge clk) begin
    if (wr_en)
      for (int b = 0; b < 4; b++)
        if (wmask[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
  end
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = take ? RESP : (state_q == RESP && !resp_ready) ? RESP : IDLE;
  end
  always_comb begin
    req_ready = state_q == IDLE || resp_ready;
    resp_valid = state_q == RESP;
  end
  always_comb begin
    resp_r_data_d = take ? (err || req_mem_op[3] ? 32'd0 : load_data) : resp_r_data_q;
    resp_rd_d = take ? req_rd : resp_rd_q;
    resp_is_store_d = take ? req_mem_op[3] : resp_is_store_q;
    resp_err_d = take ? err : resp_err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_r_data_q <= '0;
      resp_rd_q <= '0;
      resp_is_store_q <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      resp_r_data_q <= resp_r_data_d;
      resp_rd_q <= resp_rd_d;
      resp_is_store_q <= resp_is_store_d;
      resp_err_q <= resp_err_d;
    end
  end
  assign resp_r_data = resp_r_data_q;
  assign resp_rd = resp_rd_q;
  assign resp_is_store = resp_is_store_q;
  assign resp_err = resp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven scoreboard bench for dmem_responder
module tb_dmem_responder;
  localparam logic [3:0] LB = 4'h0, LH = 4'h1, LW = 4'h2, LBU = 4'h4, LHU = 4'h5;
  localparam logic [3:0] SB = 4'h8, SH = 4'h9, SW = 4'hA, NOP = 4'hF;
  typedef struct packed {
    logic [3:0] op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [4:0] rd;
    logic [31:0] ed;
    logic es;
    logic ee;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready, resp_valid, resp_ready = 1'b1;
  logic [3:0] req_mem_op = NOP;
  logic [31:0] req_addr = '0, req_w_data = '0, resp_r_data;
  logic [4:0] req_rd = '0, resp_rd;
  logic resp_is_store, resp_err;
  logic [31:0] exp_data = '0;
  logic exp_st = 1'b0, exp_err = 1'b0;
  logic [38:0] sb[$];
  logic [38:0] snap;
  vec_t tbl[$];
  int n_chk = 0, n_fail = 0;
  dmem_responder dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mem_op(req_mem_op),
    .req_addr(req_addr), .req_w_data(req_w_data), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_r_data(resp_r_data),
    .resp_rd(resp_rd), .resp_is_store(resp_is_store), .resp_err(resp_err)
  );
  always #5 clk = ~clk;
  function automatic vec_t v(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [4:0] rd, input logic [31:0] ed, input logic es, input logic ee);
    v = {op, addr, wd, rd, ed, es, ee};
  endfunction
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input vec_t t);
    req_valid = 1'b1;
    req_mem_op = t.op;
    req_addr = t.addr;
    req_w_data = t.wd;
    req_rd = t.rd;
    exp_data = t.ed;
    exp_st = t.es;
    exp_err = t.ee;
  endtask
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (sb.size() == 0) check("resp_expected", 64'(resp_rd), 64'h3F);
      else if (resp_ready) check("resp", 64'({resp_r_data, resp_rd, resp_is_store, resp_err}), 64'(sb.pop_front()));
    end
    if (!rst && req_valid && req_ready && req_mem_op != NOP)
      sb.push_back({exp_data, req_rd, exp_st, exp_err});
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    tbl.push_back(v(SW,  32'h10,   32'hDEADBEEF, 5'd1,  32'h0,        1, 0));
    tbl.push_back(v(LW,  32'h10,   32'h0,        5'd2,  32'hDEADBEEF, 0, 0));
    tbl.push_back(v(SB,  32'h13,   32'h80,       5'd3,  32'h0,        1, 0));
    tbl.push_back(v(LB,  32'h13,   32'h0,        5'd4,  32'hFFFFFF80, 0, 0));
    tbl.push_back(v(LBU, 32'h13,   32'h0,        5'd5,  32'h00000080, 0, 0));
    tbl.push_back(v(LW,  32'h10,   32'h0,        5'd6,  32'h80ADBEEF, 0, 0));
    tbl.push_back(v(SW,  32'h20,   32'h11223344, 5'd7,  32'h0,        1, 0));
    tbl.push_back(v(SH,  32'h22,   32'h00008001, 5'd8,  32'h0,        1, 0));
    tbl.push_back(v(LH,  32'h22,   32'h0,        5'd9,  32'hFFFF8001, 0, 0));
    tbl.push_back(v(LHU, 32'h22,   32'h0,        5'd10, 32'h00008001, 0, 0));
    tbl.push_back(v(LH,  32'h21,   32'h0,        5'd11, 32'h0,        0, 1));
    tbl.push_back(v(LW,  32'h20,   32'h0,        5'd12, 32'h80013344, 0, 0));
    tbl.push_back(v(SW,  32'h30,   32'hCAFEF00D, 5'd13, 32'h0,        1, 0));
    tbl.push_back(v(SW,  32'h31,   32'h12345678, 5'd14, 32'h0,        1, 1));
    tbl.push_back(v(LW,  32'h30,   32'h0,        5'd15, 32'hCAFEF00D, 0, 0));
    tbl.push_back(v(SW,  32'h0,    32'hA5A50001, 5'd16, 32'h0,        1, 0));
    tbl.push_back(v(LW,  32'h4000, 32'h0,        5'd17, 32'hA5A50001, 0, 0));
    tbl.push_back(v(LH,  32'h20,   32'h0,        5'd18, 32'h00003344, 0, 0));
    tbl.push_back(v(LB,  32'h21,   32'h0,        5'd19, 32'h00000033, 0, 0));
    tbl.push_back(v(4'h3, 32'h10,  32'h0,        5'd20, 32'h0,        0, 1));
    tbl.push_back(v(4'hB, 32'h10,  32'hFFFFFFFF, 5'd21, 32'h0,        1, 1));
    tbl.push_back(v(NOP, 32'h10,   32'h0,        5'd22, 32'h0,        0, 0));
    tbl.push_back(v(LW,  32'h10,   32'h0,        5'd23, 32'h80ADBEEF, 0, 0));
    tbl.push_back(v(SH,  32'h12,   32'hFFFF7FFE, 5'd24, 32'h0,        1, 0));
    tbl.push_back(v(LW,  32'h10,   32'h0,        5'd25, 32'h7FFEBEEF, 0, 0));
    tbl.push_back(v(SB,  32'h30,   32'h000001FF, 5'd26, 32'h0,        1, 0));
    tbl.push_back(v(LBU, 32'h30,   32'h0,        5'd27, 32'h000000FF, 0, 0));
    tbl.push_back(v(LB,  32'h32,   32'h0,        5'd28, 32'hFFFFFFFE, 0, 0));
    tbl.push_back(v(LHU, 32'h33,   32'h0,        5'd29, 32'h0,        0, 1));
    tbl.push_back(v(4'h6, 32'h0,   32'h0,        5'd30, 32'h0,        0, 1));
    tbl.push_back(v(SH,  32'h01,   32'hFFFFFFFF, 5'd31, 32'h0,        1, 1));
    tbl.push_back(v(LW,  32'h0,    32'h0,        5'd1,  32'hA5A50001, 0, 0));
    tbl.push_back(v(LH,  32'h12,   32'h0,        5'd0,  32'h00007FFE, 0, 0));
    tbl.push_back(v(SB,  32'h31,   32'h000000AB, 5'd2,  32'h0,        1, 0));
    tbl.push_back(v(LW,  32'h30,   32'h0,        5'd3,  32'hCAFEABFF, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs", 64'({resp_valid, resp_r_data, resp_rd, resp_is_store, resp_err}), 64'h0);
    check("reset_req_ready", 64'(req_ready), 64'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    drive(v(LW, 32'h10, 32'h0, 5'd9, 32'h7FFEBEEF, 0, 0));
    @(posedge clk); #1;
    drive(v(LW, 32'h30, 32'h0, 5'd10, 32'hCAFEABFF, 0, 0));
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin
        snap = {resp_r_data, resp_rd, resp_is_store, resp_err};
        check("hold_first", 64'(snap), 64'({32'h7FFEBEEF, 5'd9, 1'b0, 1'b0}));
      end else check("hold_stable", 64'({resp_r_data, resp_rd, resp_is_store, resp_err}), 64'(snap));
      check("hold_req_ready", 64'(req_ready), 64'h0);
      check("hold_resp_valid", 64'(resp_valid), 64'h1);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    check("release_accept", 64'(req_ready), 64'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("no_bubble", 64'({resp_valid, resp_rd}), 64'({1'b1, 5'd10}));
    @(posedge clk); #1;
    drive(v(LW, 32'h30, 32'h0, 5'd11, 32'hCAFEABFF, 0, 0));
    resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("pending_before_rst", 64'({resp_valid, resp_rd}), 64'({1'b1, 5'd11}));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("rst_drop", 64'({resp_valid, resp_r_data, resp_rd, resp_is_store, resp_err}), 64'h0);
    check("rst_req_ready", 64'(req_ready), 64'h1);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    drive(v(NOP, 32'h30, 32'h0, 5'd7, 32'h0, 0, 0));
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("nop_no_resp", 64'(resp_valid), 64'h0);
    repeat (2) @(posedge clk);
    check("sb_empty", 64'(sb.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
